// File: rtl/vga_fb_pkg.sv
// Shared constants and enumerations for the VGA framebuffer arbiter slice.
package vga_fb_pkg;

   localparam int unsigned ADDR_W    = 19;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned FB_WIDTH  = 640;
   localparam int unsigned FB_HEIGHT = 480;
   localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_SCAN,
      GNT_CLR,
      GNT_CPU
   } grant_t;

   typedef enum logic [1:0] {
      CLR_IDLE,
      CLR_DRAIN,
      CLR_FILL
   } clr_state_t;

endpackage

// File: rtl/vga_wr_fifo.sv
// Small synchronous FIFO buffering processor framebuffer stores as {addr, data}.
module vga_wr_fifo #(
   parameter int unsigned WIDTH = 27,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads > screen clear > buffered CPU stores.
module vga_fb_arbiter #(
   parameter int unsigned ADDR_W     = vga_fb_pkg::ADDR_W,
   parameter int unsigned DATA_W     = vga_fb_pkg::DATA_W,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned FB_PIXELS  = vga_fb_pkg::FB_PIXELS
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_data,
   output logic              cpu_stall,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_color,
   output logic              clr_busy,
   input  logic              scan_req,
   input  logic [ADDR_W-1:0] scan_addr,
   output logic [DATA_W-1:0] scan_data,
   output logic              scan_valid,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [DATA_W-1:0] fb_wdata,
   output logic              fb_we,
   input  logic [DATA_W-1:0] fb_rdata
);

   import vga_fb_pkg::*;

   localparam int unsigned       ENT_W     = ADDR_W + DATA_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

   clr_state_t        state;
   clr_state_t        state_nx;
   logic [ADDR_W-1:0] clr_cnt;
   logic [ADDR_W-1:0] clr_cnt_nx;
   logic [DATA_W-1:0] clr_col;
   logic [DATA_W-1:0] clr_col_nx;
   grant_t            gnt;
   logic              fifo_push;
   logic              fifo_full;
   logic              fifo_empty;
   logic [ENT_W-1:0]  fifo_head;
   logic [1:0]        sv_pipe;

   assign clr_busy  = (state != CLR_IDLE);
   assign cpu_stall = fifo_full | clr_busy;
   assign fifo_push = cpu_we & ~cpu_stall;

   vga_wr_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .push_data ({cpu_addr, cpu_data}),
      .pop       (gnt == GNT_CPU),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      gnt = GNT_NONE;
      if (scan_req)                gnt = GNT_SCAN;
      else if (state == CLR_FILL)  gnt = GNT_CLR;
      else if (!fifo_empty)        gnt = GNT_CPU;
   end

   // DRAIN lets stores accepted up to the clr_start cycle land before any fill.
   always_comb begin
      state_nx   = state;
      clr_cnt_nx = clr_cnt;
      clr_col_nx = clr_col;
      case (state)
         CLR_IDLE: begin
            if (clr_start) begin
               state_nx   = CLR_DRAIN;
               clr_col_nx = clr_color;
               clr_cnt_nx = '0;
            end
         end
         CLR_DRAIN: begin
            if (fifo_empty) state_nx = CLR_FILL;
         end
         CLR_FILL: begin
            if (gnt == GNT_CLR) begin
               if (clr_cnt == LAST_ADDR) state_nx   = CLR_IDLE;
               else                      clr_cnt_nx = clr_cnt + 1'b1;
            end
         end
         default: state_nx = CLR_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= CLR_IDLE;
         clr_cnt <= '0;
         clr_col <= '0;
      end else begin
         state   <= state_nx;
         clr_cnt <= clr_cnt_nx;
         clr_col <= clr_col_nx;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fb_we    <= 1'b0;
         fb_addr  <= '0;
         fb_wdata <= '0;
         sv_pipe  <= '0;
      end else begin
         case (gnt)
            GNT_SCAN: begin
               fb_we    <= 1'b0;
               fb_addr  <= scan_addr;
               fb_wdata <= '0;
            end
            GNT_CLR: begin
               fb_we    <= 1'b1;
               fb_addr  <= clr_cnt;
               fb_wdata <= clr_col;
            end
            GNT_CPU: begin
               fb_we    <= 1'b1;
               fb_addr  <= fifo_head[ENT_W-1:DATA_W];
               fb_wdata <= fifo_head[DATA_W-1:0];
            end
            default: begin
               fb_we    <= 1'b0;
               fb_addr  <= '0;
               fb_wdata <= '0;
            end
         endcase
         sv_pipe <= {sv_pipe[0], (gnt == GNT_SCAN)};
      end
   end

   // RAM data returns in the second cycle after the grant, aligned with sv_pipe[1].
   assign scan_valid = sv_pipe[1];
   assign scan_data  = sv_pipe[1] ? fb_rdata : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed steps plus random traffic against a write-order model.
module tb_vga_fb_arbiter;

   localparam int unsigned AW    = 19;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned NPIX  = 64;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      bit            fill;
   } wr_t;

   logic          clock = 1'b0;
   logic          reset;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_data;
   logic          cpu_stall;
   logic          clr_start;
   logic [DW-1:0] clr_color;
   logic          clr_busy;
   logic          scan_req;
   logic [AW-1:0] scan_addr;
   logic [DW-1:0] scan_data;
   logic          scan_valid;
   logic [AW-1:0] fb_addr;
   logic [DW-1:0] fb_wdata;
   logic          fb_we;
   logic [DW-1:0] fb_rdata;

   always #5 clock = ~clock;

   vga_fb_arbiter #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .FIFO_DEPTH (DEPTH),
      .FB_PIXELS  (NPIX)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_data   (cpu_data),
      .cpu_stall  (cpu_stall),
      .clr_start  (clr_start),
      .clr_color  (clr_color),
      .clr_busy   (clr_busy),
      .scan_req   (scan_req),
      .scan_addr  (scan_addr),
      .scan_data  (scan_data),
      .scan_valid (scan_valid),
      .fb_addr    (fb_addr),
      .fb_wdata   (fb_wdata),
      .fb_we      (fb_we),
      .fb_rdata   (fb_rdata)
   );

   // Framebuffer RAM: synchronous read, data one cycle after the address.
   logic [DW-1:0] ram [0:(1<<AW)-1];
   always @(posedge clock) begin
      if (fb_we) ram[fb_addr] <= fb_wdata;
      fb_rdata <= ram[fb_addr];
   end

   int            n_assert = 0;
   int            n_fail   = 0;
   wr_t           exp_q[$];
   logic [DW-1:0] exp_img [int unsigned];
   int            pushes, cpu_wr;
   bit            clr_active, clr_done, exp_busy, exp_stall;
   bit            d_req, d_known;
   logic [DW-1:0] d_val;

   initial begin
      #500_000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_fb_we"},      fb_we,      0);
      check({tag, "_fb_addr"},    fb_addr,    0);
      check({tag, "_fb_wdata"},   fb_wdata,   0);
      check({tag, "_scan_valid"}, scan_valid, 0);
      check({tag, "_scan_data"},  scan_data,  0);
      check({tag, "_clr_busy"},   clr_busy,   0);
      check({tag, "_cpu_stall"},  cpu_stall,  0);
   endtask

   task automatic model_clear();
      exp_q.delete();
      pushes = 0; cpu_wr = 0;
      clr_active = 0; clr_done = 0;
      exp_busy = 0; exp_stall = 0;
      d_req = 0; d_known = 0; d_val = '0;
   endtask

   task automatic observe(input bit nreq, input logic [AW-1:0] naddr);
      wr_t e;
      if (fb_we) begin
         if (exp_q.size() == 0) check("wr_unexpected", fb_we, 0);
         else begin
            e = exp_q.pop_front();
            check("wr", {fb_addr, fb_wdata}, {e.a, e.d});
            exp_img[e.a] = e.d;
            if (e.fill) begin
               if (e.a == AW'(NPIX - 1)) clr_done = 1;
            end else cpu_wr++;
         end
      end
      if (d_req) begin
         check("scan_valid", scan_valid, 1);
         if (d_known) check("scan_data", scan_data, d_val);
      end else check("scan_idle", scan_valid, 0);
      d_req = nreq;
      if (nreq) begin
         check("scan_port", {fb_we, fb_addr}, {1'b0, naddr});
         d_known = exp_img.exists(naddr);
         d_val   = d_known ? exp_img[naddr] : '0;
      end
      exp_busy  = clr_active && !clr_done;
      exp_stall = exp_busy || ((pushes - cpu_wr) >= DEPTH);
      check("clr_busy",  clr_busy,  exp_busy);
      check("cpu_stall", cpu_stall, exp_stall);
   endtask

   // Inputs for the current cycle are already applied; record their effect, then observe the next cycle.
   task automatic run_cycle();
      bit            nreq;
      logic [AW-1:0] naddr;
      if (cpu_we && !exp_stall) begin
         exp_q.push_back('{a: cpu_addr, d: cpu_data, fill: 1'b0});
         pushes++;
      end
      if (clr_start && !exp_busy) begin
         for (int unsigned i = 0; i < NPIX; i++)
            exp_q.push_back('{a: AW'(i), d: clr_color, fill: 1'b1});
         clr_active = 1;
         clr_done   = 0;
      end
      nreq  = scan_req;
      naddr = scan_addr;
      @(negedge clock);
      observe(nreq, naddr);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      cpu_we = 0; scan_req = 0; clr_start = 0;
      while ((exp_q.size() != 0 || exp_busy || d_req) && n < budget) begin
         run_cycle();
         n++;
      end
      check("drain", exp_q.size(), 0);
      run_cycle();
   endtask

   task automatic do_reset(input string tag, input int cycles);
      cpu_we = 0; scan_req = 0; clr_start = 0;
      @(posedge clock);
      #1 reset = 0;
      model_clear();
      repeat (cycles) @(negedge clock);
      check_zero(tag);
      reset = 1;
   endtask

   initial begin
      int acc_at;
      int busy_cnt;
      reset = 1; cpu_we = 0; cpu_addr = '0; cpu_data = '0;
      clr_start = 0; clr_color = '0; scan_req = 0; scan_addr = '0;
      model_clear();

      // Reset state, then a single store appearing two cycles after acceptance.
      #2 reset = 0;
      repeat (2) @(negedge clock);
      check_zero("reset");
      reset = 1;
      cpu_we = 1; cpu_addr = 19'h00010; cpu_data = 8'h3C;
      run_cycle();
      cpu_we = 0;
      check("store_lat_t1", fb_we, 0);
      run_cycle();
      check("store_lat_we", fb_we, 1);
      check("store_lat_addr", fb_addr, 19'h00010);
      check("store_lat_data", fb_wdata, 8'h3C);
      wait_idle(20);

      // FIFO fills behind continuous scan traffic; the fifth store waits one freed slot.
      scan_req = 1;
      for (int i = 0; i < 5; i++) begin
         scan_addr = AW'($urandom_range(0, 127));
         cpu_we = 1; cpu_addr = AW'(32'h100 + i); cpu_data = DW'(8'h11 * (i + 1));
         check("fifo_stall", cpu_stall, (i == 4));
         if (i < 4) run_cycle();
      end
      scan_req = 0;
      acc_at = -1;
      for (int n = 0; n < 10; n++) begin
         if (!exp_stall) begin
            acc_at = n;
            run_cycle();
            break;
         end
         run_cycle();
      end
      check("fifo_accept_cycle", acc_at, 1);
      wait_idle(30);

      // Read-back of a CPU store through the scan port.
      cpu_we = 1; cpu_addr = 19'h12345; cpu_data = 8'hA5;
      run_cycle();
      wait_idle(20);
      scan_req = 1; scan_addr = 19'h12345;
      run_cycle();
      scan_req = 0;
      run_cycle();
      check("readback_valid", scan_valid, 1);
      check("readback_data", scan_data, 8'hA5);
      wait_idle(10);

      // Clear requested while two stores are still queued.
      scan_req = 1; scan_addr = 19'h0;
      for (int i = 0; i < 2; i++) begin
         cpu_we = 1; cpu_addr = AW'(32'h200 + i); cpu_data = DW'(8'hC0 + i);
         run_cycle();
      end
      cpu_we = 0; clr_start = 1; clr_color = 8'h1F;
      run_cycle();
      clr_start = 0; scan_req = 0;
      check("clr_rise", clr_busy, 1);
      check("clr_stall", cpu_stall, 1);
      wait_idle(3 * NPIX);

      // Busy length with an empty FIFO and no scans; a second clr_start mid-clear is ignored.
      clr_start = 1; clr_color = 8'h5A;
      run_cycle();
      clr_start = 0;
      busy_cnt = 0;
      for (int n = 0; n < int'(NPIX) + 20; n++) begin
         if (!clr_busy) break;
         busy_cnt++;
         if (n == 10) begin clr_start = 1; clr_color = 8'hEE; end
         run_cycle();
         clr_start = 0;
      end
      check("busy_len", busy_cnt, NPIX + 1);
      wait_idle(20);

      // Scan reads interleaved with an active fill.
      clr_start = 1; clr_color = 8'h66;
      run_cycle();
      clr_start = 0;
      repeat (20) run_cycle();
      scan_req = 1;
      for (int i = 0; i < 3; i++) begin
         scan_addr = AW'(i);
         run_cycle();
      end
      scan_req = 0;
      wait_idle(2 * NPIX);

      // Random mix of stores, scans and occasional clears.
      for (int n = 0; n < 1500; n++) begin
         cpu_we    = ($urandom_range(0, 1) == 1);
         cpu_addr  = AW'($urandom_range(0, 127));
         cpu_data  = DW'($urandom);
         scan_req  = ($urandom_range(0, 3) == 0);
         scan_addr = AW'($urandom_range(0, 127));
         clr_start = ($urandom_range(0, 299) == 0);
         clr_color = DW'($urandom);
         run_cycle();
      end
      wait_idle(4 * NPIX);

      // Reset in the middle of a fill, then a normal store.
      clr_start = 1; clr_color = 8'h99;
      run_cycle();
      clr_start = 0;
      repeat (15) run_cycle();
      do_reset("rst_fill", 2);
      cpu_we = 1; cpu_addr = 19'h00020; cpu_data = 8'h77;
      run_cycle();
      cpu_we = 0;
      run_cycle();
      check("post_rst_we", fb_we, 1);
      check("post_rst_addr", fb_addr, 19'h00020);
      check("post_rst_data", fb_wdata, 8'h77);
      wait_idle(20);

      // Reset with queued stores: they must be discarded.
      scan_req = 1; scan_addr = 19'h0;
      for (int i = 0; i < 2; i++) begin
         cpu_we = 1; cpu_addr = AW'(32'h300 + i); cpu_data = DW'(8'h40 + i);
         run_cycle();
      end
      do_reset("rst_queued", 2);
      repeat (6) run_cycle();
      wait_idle(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
